// File: rtl/vertex_project_pkg.sv
// Shared constants, trig table and vertex field layout for the vertex projection path.
package vertex_project_pkg;

  // Fixed-point and screen-mapping constants
  localparam int Q14_ONE      = 16384;
  localparam int SCREEN_SHIFT = 17;   // drop Q14 fraction plus /8 model-to-screen scale
  localparam int Y_SHIFT      = 3;    // y only gets the /8 scale

  localparam int CENTER_X_DEF = 160;
  localparam int CENTER_Y_DEF = 120;
  localparam int MAX_X_DEF    = 319;
  localparam int MAX_Y_DEF    = 239;

  // Vertex field slice convention, shared with the shape LUT: {x, y, z}
  localparam int COORD_W  = 16;
  localparam int VERTEX_W = 3 * COORD_W;
  localparam int VX_LSB   = 32;
  localparam int VY_LSB   = 16;
  localparam int VZ_LSB   = 0;

  // First quadrant of sin in signed Q1.14, k = 0..4 (22.5 deg steps)
  localparam logic signed [15:0] SIN_Q14 [5] = '{16'sd0, 16'sd6270, 16'sd11585,
                                                 16'sd15137, 16'sd16384};

  function automatic logic signed [15:0] vtx_x(input logic [VERTEX_W-1:0] v);
    return v[VX_LSB +: COORD_W];
  endfunction

  function automatic logic signed [15:0] vtx_y(input logic [VERTEX_W-1:0] v);
    return v[VY_LSB +: COORD_W];
  endfunction

  function automatic logic signed [15:0] vtx_z(input logic [VERTEX_W-1:0] v);
    return v[VZ_LSB +: COORD_W];
  endfunction

  // Full 16-entry sin from the quarter table: mirror within a half turn,
  // negate for the second half turn.
  function automatic logic signed [15:0] sin_lookup(input logic [3:0] k);
    logic [2:0]        p;
    logic [2:0]        idx;
    logic signed [15:0] v;
    p   = k[2:0];
    idx = (p > 3'd4) ? (3'd0 - p) : p;   // 5,6,7 -> 3,2,1
    v   = SIN_Q14[idx];
    return k[3] ? -v : v;
  endfunction

endpackage

// File: rtl/vertex_project_trig_lut.sv
// Combinational sin/cos lookup for 16 angle steps; cos is sin a quarter turn ahead.
module trig_lut
  import vertex_project_pkg::*;
(
  input  logic [3:0]  angle,
  output logic [15:0] sin,
  output logic [15:0] cos
);

  assign sin = sin_lookup(angle);
  assign cos = sin_lookup(angle + 4'd4);   // wraps mod 16

endmodule

// File: rtl/vertex_project.sv
// Three-stage Y-axis rotate + project + clamp pipeline with valid/ready flow control.
module vertex_project
  import vertex_project_pkg::*;
#(
  parameter int CENTER_X = CENTER_X_DEF,
  parameter int CENTER_Y = CENTER_Y_DEF,
  parameter int MAX_X    = MAX_X_DEF,
  parameter int MAX_Y    = MAX_Y_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_vertex,
  input  logic [3:0]  in_angle,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [8:0]  out_x,
  output logic [8:0]  out_y,
  output logic        out_clipped
);

  localparam int STAGES = 3;
  localparam logic signed [17:0] MAXX_S = 18'(MAX_X);
  localparam logic signed [17:0] MAXY_S = 18'(MAX_Y);

  logic              advance;
  logic [STAGES:1]   vld_pipe;

  logic [15:0]        lut_sin, lut_cos;

  logic signed [15:0] s1_x, s1_y, s1_z, s1_sin, s1_cos;
  logic signed [31:0] prod_x, prod_z;
  logic signed [32:0] s2_xr;
  logic signed [15:0] s2_y;

  logic signed [17:0] sx, sy;
  logic [8:0]         clamp_x, clamp_y;
  logic               clip_x, clip_y;

  // Whole pipe moves together unless a result is parked at the output
  assign advance   = ~vld_pipe[STAGES] | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];

  trig_lut u_trig (
    .angle (in_angle),
    .sin   (lut_sin),
    .cos   (lut_cos)
  );

  // Valid bits shift with the data; reset flushes anything in flight
  always_ff @(posedge clock) begin
    if (reset)        vld_pipe <= '0;
    else if (advance) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // S1: capture vertex fields and trig values for this vertex's angle
  always_ff @(posedge clock) begin
    if (advance) begin
      s1_x   <= vtx_x(in_vertex);
      s1_y   <= vtx_y(in_vertex);
      s1_z   <= vtx_z(in_vertex);
      s1_sin <= $signed(lut_sin);
      s1_cos <= $signed(lut_cos);
    end
  end

  assign prod_x = s1_x * s1_cos;
  assign prod_z = s1_z * s1_sin;

  // S2: rotated X (33-bit so the sum of two full-scale products cannot wrap)
  always_ff @(posedge clock) begin
    if (advance) begin
      s2_xr <= 33'(prod_x) + 33'(prod_z);
      s2_y  <= s1_y;
    end
  end

  // Arithmetic shift by slicing the sign-carrying upper bits: floors toward -inf
  assign sx = 18'($signed(s2_xr[32:SCREEN_SHIFT])) + 18'(CENTER_X);
  assign sy = 18'($signed(s2_y[15:Y_SHIFT]))       + 18'(CENTER_Y);

  // Clamp both coordinates onto the visible screen
  always_comb begin
    clip_x  = 1'b0;
    clip_y  = 1'b0;
    clamp_x = sx[8:0];
    clamp_y = sy[8:0];
    if (sx[17]) begin
      clamp_x = '0;
      clip_x  = 1'b1;
    end else if (sx > MAXX_S) begin
      clamp_x = MAXX_S[8:0];
      clip_x  = 1'b1;
    end
    if (sy[17]) begin
      clamp_y = '0;
      clip_y  = 1'b1;
    end else if (sy > MAXY_S) begin
      clamp_y = MAXY_S[8:0];
      clip_y  = 1'b1;
    end
  end

  // S3: output register, held stable while downstream stalls
  always_ff @(posedge clock) begin
    if (reset) begin
      out_x       <= '0;
      out_y       <= '0;
      out_clipped <= 1'b0;
    end else if (advance) begin
      out_x       <= clamp_x;
      out_y       <= clamp_y;
      out_clipped <= clip_x | clip_y;
    end
  end

endmodule

// File: doc/vertex_project.md
VERTEX_PROJECT -- requirements
Module: vertex_project

Interface
REQ-001 Parameters SHALL be: CENTER_X, default 160, screen X origin; CENTER_Y, default 120, screen Y origin; MAX_X, default 319; MAX_Y, default 239.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_vertex/in_angle valid this cycle.
REQ-005 in_ready  output  1  stage accepts input this cycle.
REQ-006 in_vertex  input  48  packed {x[47:32], y[31:16], z[15:0]}, each signed 16-bit model coordinate.
REQ-007 in_angle  input  4  rotation about Y axis; angle = in_angle*22.5 deg.
REQ-008 out_valid  output  1  out_x/out_y/out_clipped valid.
REQ-009 out_ready  input  1  downstream line-drawer consumes output this cycle.
REQ-010 out_x  output  9  screen X, 0..MAX_X.
REQ-011 out_y  output  9  screen Y, 0..MAX_Y.
REQ-012 out_clipped  output  1  either coordinate was clamped.

Function
REQ-013 The block SHALL be a 3-stage pipeline: S1 registers the vertex and LUT sin/cos; S2 registers the products and sum; S3 registers the shifted, offset and clamped result.
REQ-014 The pipeline SHALL advance when advance = ~out_valid | out_ready; in_ready SHALL equal advance; all stages hold when advance=0.
REQ-015 A transfer SHALL occur only when in_valid & in_ready; output handshake SHALL complete only when out_valid & out_ready.
REQ-016 Latency SHALL be 3 cycles from input transfer to out_valid with no backpressure; throughput SHALL be 1 vertex/cycle.
REQ-017 The trig LUT SHALL use signed Q1.14 sin values for k=0..4: 0, 6270, 11585, 15137, 16384, extended by symmetry over 16 entries; cos(k) = sin((k+4) mod 16).
REQ-018 X rotation SHALL be xr = x*cos + z*sin using 32-bit signed products and a 33-bit signed sum.
REQ-019 Screen X SHALL be sx = (xr >>> 17) + CENTER_X (Q14 removal plus /8 scale), computed at 18 bits signed; the arithmetic shift floors toward minus infinity.
REQ-020 Screen Y SHALL be sy = (y >>> 3) + CENTER_Y; y is not rotated and is not multiplied.
REQ-021 The block SHALL clamp sx<0 to 0 and sx>MAX_X to MAX_X, and SHALL apply the same rule to sy with MAX_Y; out_clipped SHALL be 1 if either coordinate was clamped.
REQ-022 in_angle SHALL be sampled with its vertex, so a per-vertex angle change is legal every cycle.
REQ-023 Order SHALL be preserved, and no vertex SHALL be dropped or duplicated under any out_ready pattern.
REQ-024 With out_valid=1 and out_ready=0, out_x, out_y and out_clipped SHALL remain stable.

Reset
REQ-025 While reset=1, on each clock edge all stage valids, out_valid, out_x, out_y and out_clipped SHALL be cleared to 0.
REQ-026 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight vertices; no partial result SHALL emerge afterwards.

Structure
REQ-028 A shared package SHALL hold: the Q14 constant 16384; shift constant 17; defaults 160/120/319/239; the sin table values; and a vertex field slice convention, which is also used by the shape LUT.
REQ-029 One sub-module, trig_lut, SHALL be used; it is combinational, with input angle[3:0] and outputs sin[15:0] and cos[15:0].
REQ-030 Datapath registers SHALL carry no reset; only valid bits and outputs SHALL be reset.

Verification
REQ-031 Scenario: angle 0, vertex {FC18, FDBF, FCD0} -> after 3 cycles out_x=35, out_y=47, clipped=0.
REQ-032 Scenario: angle 4, vertex {0000, 0000, 0330} -> out_x=262, out_y=120; vertex {FC18, FDBF, FCD0} -> out_x=58, out_y=47.
REQ-033 Scenario: angle 0, x=7FFF -> out_x=319, clipped=1; x=8000 -> out_x=0, clipped=1; y=7FFF -> out_y=239, clipped=1.
REQ-034 Scenario: out_ready=0 with 5 vertices offered back-to-back -> in_ready falls after 3 accepts; on release, all 5 emerge in order with no loss.
REQ-035 Scenario: reset pulsed with 2 vertices in flight -> out_valid=0 next cycle, no stale output, in_ready=1 after release.
REQ-036 Scenario: random in_valid/out_ready checked against a reference model -> exact match on every output.
